// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: decodes aluOp/myFunction into a 3-bit control code,
// runs single-cycle ops directly and shifts/multiplies iteratively, then holds the result.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new op; single-cycle ops resolve on acceptance
// EXEC  | iterating a shift (one bit per cycle) or a shift-add multiply
// DONE  | result valid and held until the consumer asserts outReady
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             inValid,
   output logic             inReady,
   input  logic [1:0]       aluOp,
   input  logic [3:0]       myFunction,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [2:0]       aluCnt,
   output logic             illegalOp
);

   localparam int SHAMT_W = $clog2(WIDTH);
   localparam int CNT_W   = SHAMT_W + 1;

   localparam logic [2:0] CNT_AND = 3'b000;
   localparam logic [2:0] CNT_OR  = 3'b001;
   localparam logic [2:0] CNT_ADD = 3'b010;
   localparam logic [2:0] CNT_SLL = 3'b011;
   localparam logic [2:0] CNT_SRL = 3'b100;
   localparam logic [2:0] CNT_MUL = 3'b101;
   localparam logic [2:0] CNT_SUB = 3'b110;
   localparam logic [2:0] CNT_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic [2:0]         alu_cnt_q, alu_cnt_d;
   logic               illegal_q, illegal_d;

   logic [2:0]         dec_cnt;
   logic               dec_ill;
   logic [WIDTH-1:0]   single_res;
   logic [WIDTH-1:0]   acc_next;
   logic [SHAMT_W-1:0] shamt;
   logic               slt_lt;

   assign shamt  = srcB[SHAMT_W-1:0];
   assign slt_lt = $signed(srcA) < $signed(srcB);

   always_comb begin
      dec_cnt = CNT_ADD;
      dec_ill = 1'b0;
      case (aluOp)
         2'b00: dec_cnt = CNT_ADD;
         2'b01: dec_cnt = CNT_SUB;
         2'b11: dec_cnt = CNT_OR;
         default: begin
            case (myFunction)
               4'b0000: dec_cnt = CNT_ADD;
               4'b0001: dec_cnt = CNT_SUB;
               4'b0010: dec_cnt = CNT_AND;
               4'b0011: dec_cnt = CNT_OR;
               4'b0100: dec_cnt = CNT_SLT;
               4'b0101: dec_cnt = CNT_SLL;
               4'b0110: dec_cnt = CNT_SRL;
               4'b0111: dec_cnt = CNT_MUL;
               default: begin
                  dec_cnt = CNT_ADD;
                  dec_ill = 1'b1;
               end
            endcase
         end
      endcase
   end

   // Iterative codes never reach DONE through this path; they fall to zero.
   always_comb begin
      single_res = '0;
      case (dec_cnt)
         CNT_ADD: single_res = srcA + srcB;
         CNT_SUB: single_res = srcA - srcB;
         CNT_AND: single_res = srcA & srcB;
         CNT_OR:  single_res = srcA | srcB;
         CNT_SLT: single_res = {{(WIDTH-1){1'b0}}, slt_lt};
         default: single_res = '0;
      endcase
   end

   always_comb begin
      acc_next = acc_q;
      case (alu_cnt_q)
         CNT_SLL: acc_next = acc_q << 1;
         CNT_SRL: acc_next = acc_q >> 1;
         CNT_MUL: acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
         default: acc_next = acc_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      zero_d    = zero_q;
      alu_cnt_d = alu_cnt_q;
      illegal_d = illegal_q;
      case (state_q)
         IDLE: begin
            if (inValid) begin
               alu_cnt_d = dec_cnt;
               illegal_d = dec_ill;
               case (dec_cnt)
                  CNT_SLL, CNT_SRL: begin
                     if (shamt == '0) begin
                        result_d = srcA;
                        zero_d   = (srcA == '0);
                        state_d  = DONE;
                     end else begin
                        acc_d   = srcA;
                        cnt_d   = {1'b0, shamt};
                        state_d = EXEC;
                     end
                  end
                  CNT_MUL: begin
                     acc_d    = '0;
                     mcand_d  = srcA;
                     mplier_d = srcB;
                     cnt_d    = CNT_W'(WIDTH);
                     state_d  = EXEC;
                  end
                  default: begin
                     result_d = single_res;
                     zero_d   = (single_res == '0);
                     state_d  = DONE;
                  end
               endcase
            end
         end
         EXEC: begin
            acc_d = acc_next;
            cnt_d = cnt_q - 1'b1;
            if (alu_cnt_q == CNT_MUL) begin
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
            end
            if (cnt_q <= CNT_W'(1)) begin
               result_d = acc_next;
               zero_d   = (acc_next == '0);
               state_d  = DONE;
            end
         end
         DONE: begin
            if (outReady) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         alu_cnt_q <= 3'b000;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         alu_cnt_q <= alu_cnt_d;
         illegal_q <= illegal_d;
      end
   end

   assign inReady   = (state_q == IDLE);
   assign outValid  = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign aluCnt    = alu_cnt_q;
   assign illegalOp = illegal_q;

endmodule
